// File: rtl/audio_fx_pkg.sv
// Shared types, default widths and sample saturation for the audio effect blocks.
package audio_fx_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_MEM_DEPTH  = 512;
    localparam int DEF_GAIN_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_OUT
    } dl_state_e;

    // Clamp a wide signed value into the signed range of a w-bit sample.
    function automatic logic signed [63:0] sat_sample(input logic signed [63:0] x,
                                                      input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi)      return hi;
        else if (x < lo) return lo;
        else             return x;
    endfunction

endpackage

// File: rtl/echo_mixer.sv
// Combinational echo mix: dry + ((delayed * gain) >>> GAIN_WIDTH), saturated.
module echo_mixer
    import audio_fx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int GAIN_WIDTH = DEF_GAIN_WIDTH
) (
    input  logic signed [DATA_WIDTH-1:0] dry,
    input  logic signed [DATA_WIDTH-1:0] delayed,
    input  logic        [GAIN_WIDTH-1:0] gain,
    output logic signed [DATA_WIDTH-1:0] mix
);

    // Product keeps one extra bit so the unsigned gain stays positive.
    localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] sum;
    logic signed [63:0]   sat;
    logic                 unused_sat;

    // Gain scaling never grows magnitude, so the sum fits well inside PW bits.
    always_comb begin
        prod = delayed * $signed({1'b0, gain});
        sum  = (prod >>> GAIN_WIDTH) + PW'(dry);
        sat  = sat_sample(64'(sum), DATA_WIDTH);
        mix  = sat[DATA_WIDTH-1:0];
    end

    assign unused_sat = ^sat[63:DATA_WIDTH];

endmodule

// File: rtl/delay_line_ctrl.sv
// Circular delay-buffer controller driving a dual-port sample memory.
// Optional echo mix enabled by defining DELAY_ECHO_MIX_EN.
module delay_line_ctrl
    import audio_fx_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter  int GAIN_WIDTH = DEF_GAIN_WIDTH,
    localparam int AW         = $clog2(MEM_DEPTH)
) (
    input  logic                         pi_clk,
    input  logic                         pi_sreset_n,
    input  logic signed [DATA_WIDTH-1:0] pi_data,
    input  logic                         pi_valid,
    output logic                         po_ready,
    input  logic        [AW-1:0]         pi_delay,
    input  logic        [GAIN_WIDTH-1:0] pi_gain,
    output logic signed [DATA_WIDTH-1:0] po_mem_data,
    output logic                         po_mem_w_en,
    output logic        [AW-1:0]         po_mem_w_addr,
    output logic                         po_mem_r_en,
    output logic        [AW-1:0]         po_mem_r_addr,
    input  logic signed [DATA_WIDTH-1:0] pi_mem_data,
    output logic signed [DATA_WIDTH-1:0] po_data,
    output logic                         po_valid,
    input  logic                         pi_ready
);

    dl_state_e                    state;
    logic        [AW-1:0]         wp;
    logic        [AW:0]           fill;
    logic        [AW-1:0]         d_eff;
    logic                         accept;
    logic                         primed;
    logic                         primed_q;
    logic signed [DATA_WIDTH-1:0] delayed;
    logic signed [DATA_WIDTH-1:0] result;

    // Memory ports are live only in the accept cycle; read trails write by d.
    always_comb begin
        accept        = pi_valid && po_ready;
        d_eff         = (pi_delay == '0) ? AW'(1) : pi_delay;
        primed        = (fill >= {1'b0, d_eff});
        po_mem_w_en   = accept;
        po_mem_r_en   = accept;
        po_mem_w_addr = wp;
        po_mem_r_addr = wp - d_eff;
        po_mem_data   = pi_data;
        delayed       = primed_q ? pi_mem_data : '0;
    end

`ifdef DELAY_ECHO_MIX_EN
    logic signed [DATA_WIDTH-1:0] dry_q;
    logic        [GAIN_WIDTH-1:0] gain_q;

    echo_mixer #(
        .DATA_WIDTH (DATA_WIDTH),
        .GAIN_WIDTH (GAIN_WIDTH)
    ) u_mix (
        .dry     (dry_q),
        .delayed (delayed),
        .gain    (gain_q),
        .mix     (result)
    );

    // Dry sample and gain are frozen at accept for use in WAIT.
    always_ff @(posedge pi_clk) begin
        if (!pi_sreset_n) begin
            dry_q  <= '0;
            gain_q <= '0;
        end else if (accept) begin
            dry_q  <= pi_data;
            gain_q <= pi_gain;
        end
    end
`else
    logic unused_gain;

    assign result      = delayed;
    assign unused_gain = ^pi_gain;
`endif

    // Sequencer: IDLE accepts, WAIT captures memory data, OUT holds until taken.
    always_ff @(posedge pi_clk) begin
        if (!pi_sreset_n) begin
            state    <= ST_IDLE;
            wp       <= '0;
            fill     <= '0;
            primed_q <= 1'b0;
            po_data  <= '0;
            po_valid <= 1'b0;
            po_ready <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    po_ready <= 1'b1;
                    if (accept) begin
                        wp       <= wp + AW'(1);
                        primed_q <= primed;
                        if (fill != (AW+1)'(MEM_DEPTH))
                            fill <= fill + (AW+1)'(1);
                        po_ready <= 1'b0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    po_data  <= result;
                    po_valid <= 1'b1;
                    state    <= ST_OUT;
                end
                ST_OUT: begin
                    if (pi_ready) begin
                        po_valid <= 1'b0;
                        po_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    po_valid <= 1'b0;
                    po_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed bench for delay_line_ctrl with a registered-read memory model.
module tb_delay_line_ctrl;

    localparam int DW = 16;
    localparam int MD = 8;
    localparam int GW = 8;
    localparam int AW = 3;

    logic                 pi_clk = 1'b0;
    logic                 pi_sreset_n;
    logic signed [DW-1:0] pi_data;
    logic                 pi_valid;
    logic                 po_ready;
    logic        [AW-1:0] pi_delay;
    logic        [GW-1:0] pi_gain;
    logic signed [DW-1:0] po_mem_data;
    logic                 po_mem_w_en;
    logic        [AW-1:0] po_mem_w_addr;
    logic                 po_mem_r_en;
    logic        [AW-1:0] po_mem_r_addr;
    logic signed [DW-1:0] pi_mem_data;
    logic signed [DW-1:0] po_data;
    logic                 po_valid;
    logic                 pi_ready;

    logic signed [DW-1:0] mem [MD];

    int n_cmp = 0;
    int n_err = 0;

    always #5 pi_clk = ~pi_clk;

    delay_line_ctrl #(
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (MD),
        .GAIN_WIDTH (GW)
    ) dut (
        .pi_clk        (pi_clk),
        .pi_sreset_n   (pi_sreset_n),
        .pi_data       (pi_data),
        .pi_valid      (pi_valid),
        .po_ready      (po_ready),
        .pi_delay      (pi_delay),
        .pi_gain       (pi_gain),
        .po_mem_data   (po_mem_data),
        .po_mem_w_en   (po_mem_w_en),
        .po_mem_w_addr (po_mem_w_addr),
        .po_mem_r_en   (po_mem_r_en),
        .po_mem_r_addr (po_mem_r_addr),
        .pi_mem_data   (pi_mem_data),
        .po_data       (po_data),
        .po_valid      (po_valid),
        .pi_ready      (pi_ready)
    );

    // Memory filled with a marker on reset so unprimed reads are visible if not masked.
    always @(posedge pi_clk) begin
        if (!pi_sreset_n) begin
            for (int i = 0; i < MD; i++) mem[i] <= 16'h5A5A;
            pi_mem_data <= '0;
        end else begin
            if (po_mem_w_en) mem[po_mem_w_addr] <= po_mem_data;
            if (po_mem_r_en) pi_mem_data <= mem[po_mem_r_addr];
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one sample at a negedge and check the accept-cycle memory ports.
    task automatic accept(input int data, input int dly, input int gain, input int exp_w, input int exp_r);
        int k;
        k = 0;
        while (po_ready !== 1'b1 && k < 20) begin
            @(negedge pi_clk);
            k++;
        end
        chk("ready_before_accept", po_ready, 1);
        pi_data  = data[DW-1:0];
        pi_delay = dly[AW-1:0];
        pi_gain  = gain[GW-1:0];
        pi_valid = 1'b1;
        #1;
        chk("acc_w_en", po_mem_w_en, 1);
        chk("acc_r_en", po_mem_r_en, 1);
        chk("acc_w_addr", po_mem_w_addr, exp_w);
        chk("acc_r_addr", po_mem_r_addr, exp_r);
        chk("acc_mem_data", po_mem_data, data);
        @(negedge pi_clk);
        pi_valid = 1'b0;
    endtask

    // Called at T+1: valid must still be low, rise at T+2 with the expected sample.
    task automatic expect_out(input string tag, input int exp);
        chk({tag, "_valid_t1"}, po_valid, 0);
        chk({tag, "_wen_t1"}, po_mem_w_en, 0);
        @(negedge pi_clk);
        chk({tag, "_valid_t2"}, po_valid, 1);
        chk({tag, "_data"}, po_data, exp);
        if (pi_ready) begin
            @(negedge pi_clk);
            chk({tag, "_valid_done"}, po_valid, 0);
            chk({tag, "_ready_done"}, po_ready, 1);
        end
    endtask

    task automatic do_reset();
        @(negedge pi_clk);
        pi_sreset_n = 1'b0;
        repeat (2) @(negedge pi_clk);
        pi_sreset_n = 1'b1;
        @(negedge pi_clk);
        chk("reset_ready_after", po_ready, 1);
    endtask

    initial begin
        pi_sreset_n = 1'b0;
        pi_valid    = 1'b0;
        pi_ready    = 1'b1;
        pi_data     = '0;
        pi_delay    = '0;
        pi_gain     = '0;

        // Reset state
        repeat (3) @(negedge pi_clk);
        chk("rst_ready", po_ready, 0);
        chk("rst_valid", po_valid, 0);
        chk("rst_data", po_data, 0);
        chk("rst_w_en", po_mem_w_en, 0);
        chk("rst_r_en", po_mem_r_en, 0);
        pi_sreset_n = 1'b1;
        #1;
        chk("rel_ready_same_cycle", po_ready, 0);
        @(negedge pi_clk);
        chk("rel_ready_next", po_ready, 1);

`ifdef DELAY_ECHO_MIX_EN
        // Echo mix vectors, delay 1, first sample unprimed
        accept(2000, 1, 128, 0, 7);
        expect_out("mix_first", 2000);
        accept(1000, 1, 128, 1, 0);
        expect_out("mix_half", 2000);
        accept(32000, 1, 255, 2, 1);
        expect_out("mix_pos_a", 32767);
        accept(32000, 1, 255, 3, 2);
        expect_out("mix_pos_sat", 32767);
        accept(-32768, 1, 255, 4, 3);
        expect_out("mix_neg_a", -893);
        accept(-32768, 1, 255, 5, 4);
        expect_out("mix_neg_sat", -32768);
`else
        begin
            int exp_a [6] = '{0, 0, 0, 0, 1, 2};
            // Unprimed buffer, delay 4
            for (int i = 0; i < 6; i++) begin
                accept(i + 1, 4, 0, i, (i - 4) & 7);
                expect_out("unprimed", exp_a[i]);
            end
        end

        // Pointer wrap, delay 3, 20-sample ramp
        do_reset();
        for (int n = 1; n <= 20; n++) begin
            accept(n, 3, 0, (n - 1) & 7, (n - 4) & 7);
            expect_out("ramp", (n > 3) ? n - 3 : 0);
        end

        // Backpressure: OUT held for 10 cycles with input offered
        pi_ready = 1'b0;
        accept(21, 3, 0, 4, 1);
        expect_out("bp", 18);
        pi_valid = 1'b1;
        pi_data  = 16'sd99;
        repeat (10) begin
            @(negedge pi_clk);
            chk("bp_valid", po_valid, 1);
            chk("bp_data", po_data, 18);
            chk("bp_ready", po_ready, 0);
            chk("bp_w_en", po_mem_w_en, 0);
            chk("bp_r_en", po_mem_r_en, 0);
        end
        pi_valid = 1'b0;
        pi_ready = 1'b1;
        @(negedge pi_clk);
        chk("bp_release_valid", po_valid, 0);
        chk("bp_release_ready", po_ready, 1);

        // Reset asserted while in WAIT
        accept(22, 3, 0, 5, 2);
        pi_sreset_n = 1'b0;
        @(negedge pi_clk);
        chk("midrst_valid", po_valid, 0);
        chk("midrst_data", po_data, 0);
        chk("midrst_ready", po_ready, 0);
        pi_sreset_n = 1'b1;
        @(negedge pi_clk);
        chk("midrst_ready_after", po_ready, 1);

        // Delay 0 treated as 1; fill cleared by the reset above
        accept(7, 0, 0, 0, 7);
        expect_out("d0_first", 0);
        accept(8, 0, 0, 1, 0);
        expect_out("d0_second", 7);
        accept(9, 1, 0, 2, 1);
        expect_out("d1_third", 8);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/delay_line_ctrl.md
# delay_line_ctrl

Sequencing controller that runs the shared dual-port sample memory as a circular delay buffer for the echo/delay effect. Each accepted input sample is written at the write pointer. In the same cycle, the sample written `pi_delay` samples earlier is read back. The delayed sample, optionally mixed with the dry sample, is returned on a valid/ready output stream. It sits between the audio input stream and the effect output stage, and drives the memory's write/read ports directly.

## Interface
- `DATA_WIDTH`, 16: signed sample width.
- `MEM_DEPTH`, 512: buffer depth in samples; must be a power of two. AW = $clog2(MEM_DEPTH).
- `GAIN_WIDTH`, 8: echo gain width (used only with `DELAY_ECHO_MIX_EN`).
- `pi_clk` in 1: single clock.
- `pi_sreset_n` in 1: synchronous reset, active-low.
- `pi_data` in DATA_WIDTH: dry input sample, signed.
- `pi_valid` in 1: input sample valid.
- `po_ready` out 1: controller can accept a sample.
- `pi_delay` in AW: delay in samples; 0 treated as 1.
- `pi_gain` in GAIN_WIDTH: unsigned echo gain, Q0.GAIN_WIDTH.
- `po_mem_data` out DATA_WIDTH: memory write data.
- `po_mem_w_en` out 1: memory write enable.
- `po_mem_w_addr` out AW: memory write address.
- `po_mem_r_en` out 1: memory read enable.
- `po_mem_r_addr` out AW: memory read address.
- `pi_mem_data` in DATA_WIDTH: registered memory read data, valid one cycle after `po_mem_r_en`.
- `po_data` out DATA_WIDTH: output sample, signed.
- `po_valid` out 1: output sample valid.
- `pi_ready` in 1: downstream accepts output.
- The top level ties the memory's active-high reset to ~`pi_sreset_n`.

## Operation
- FSM states:
  - IDLE: `po_ready`=1. On accept (`pi_valid`&&`po_ready`) go to WAIT.
  - WAIT: capture `pi_mem_data`, form the result, go to OUT.
  - OUT: `po_valid`=1. On `pi_ready` go to IDLE.
- Accept cycle, all combinational from the accept term:
  - `po_mem_w_en`=`po_mem_r_en`=1.
  - `po_mem_w_addr`=wp, `po_mem_data`=`pi_data`.
  - `po_mem_r_addr`=(wp − d) mod MEM_DEPTH, with d = max(`pi_delay`,1). Uses natural AW-bit wrap.
- Outside the accept cycle, both memory enables are 0.
- `pi_delay` and `pi_gain` are sampled only at accept. Changes while busy affect the next sample only.
- wp increments mod MEM_DEPTH on each accept (MEM_DEPTH−1 → 0).
- Fill counter (AW+1 bits):
  - Counts accepted samples, saturating at MEM_DEPTH.
  - If fill < d at accept (buffer not primed), the delayed sample is forced to 0 in WAIT instead of using `pi_mem_data`.
  - The dry sample is registered at accept for use in WAIT.
- Output register `po_data` is loaded in WAIT and held stable through OUT until the handshake completes.
- Reset (`pi_sreset_n`=0 at a clock edge, at any state, including mid-OUT):
  - State → IDLE, wp=0, fill=0.
  - `po_data`=0, `po_valid`=0.
  - An in-flight sample is dropped.
- `po_ready`=0 while `pi_sreset_n` is low; it becomes 1 the first cycle after release.

## Timing
- Accept at cycle T → `po_valid`=1 from cycle T+2.
- Minimum sample interval is 3 cycles, when `pi_ready` is already high at T+2.
- Output backpressure holds OUT indefinitely. No input is accepted until the output handshake completes.
- No combinational path from `pi_ready` to `po_ready`; `po_ready` is a function of the state only.
- Read and write never target the same address in the same cycle (d ≥ 1).

## Configuration
- `DELAY_ECHO_MIX_EN` undefined:
  - `po_data` = delayed sample (pure delay).
  - `pi_gain` is ignored.
- `DELAY_ECHO_MIX_EN` defined:
  - `po_data` = sat(dry + ((delayed × gain) >>> GAIN_WIDTH)).
  - Signed × unsigned product; arithmetic shift.
  - Sum computed at DATA_WIDTH+1 bits, saturated to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - Latency and handshake are unchanged.

## Structure
- Package `audio_fx_pkg`:
  - FSM state enum typedef (IDLE/WAIT/OUT).
  - Sample-saturation function.
  - Default width constants.
- Sub-module `echo_mixer` (combinational gain-multiply, add and saturate) is instantiated only under `DELAY_ECHO_MIX_EN`.

## Test plan
- Unprimed buffer: reset, delay=4, feed 1,2,3,4,5,6, `pi_ready`=1 → outputs 0,0,0,0,1,2 (pure delay).
- Pointer wrap: MEM_DEPTH=8, delay=3, feed 20 ramp samples → sample n outputs n−3; `po_mem_w_addr` wraps 7→0; `po_mem_r_addr` correct across the wrap.
- Backpressure: hold `pi_ready`=0 for 10 cycles in OUT → `po_data` stable, `po_ready`=0, no memory enables; release → handshake, then `po_ready`=1 on the next cycle.
- Reset mid-operation: assert `pi_sreset_n`=0 during WAIT → next cycle `po_valid`=0 and `po_data`=0; after release the first delayed output is 0 (fill reset).
- Delay 0 and latency: delay=0 behaves as delay 1; `po_valid` rises exactly 2 cycles after accept.
- With `DELAY_ECHO_MIX_EN`, 16-bit samples:
  - gain=128, dry=1000, delayed=2000 → 2000.
  - dry=32000, delayed=32000, gain=255 → saturated 32767.
  - dry=−32768, delayed=−32768, gain=255 → −32768.
